// File: rtl/usb11_pkg.sv
// Shared encodings for the USB 1.1 master controller: command ops, result tags,
// handshake bytes and the controller state enum.
package usb11_pkg;

    localparam logic [1:0] OP_CTRL  = 2'b00;
    localparam logic [1:0] OP_BYTE  = 2'b01;
    localparam logic [1:0] OP_PKT   = 2'b10;
    localparam logic [1:0] OP_LINES = 2'b11;

    localparam logic [3:0] TAG_DATA  = 4'h0;
    localparam logic [3:0] TAG_BADCH = 4'hC;
    localparam logic [3:0] TAG_FRAME = 4'hD;
    localparam logic [3:0] TAG_TMO   = 4'hE;
    localparam logic [3:0] TAG_LINES = 4'hF;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] ACK_PID   = 8'hD2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_SLOT,
        ST_SENT,
        ST_RDATA,
        ST_GAP,
        ST_SYNC,
        ST_PID
    } state_t;

endpackage

// File: rtl/usb11_res_buf.sv
// Two-entry result FIFO; head is slot0. A push into a full buffer is dropped
// unless a pop happens in the same cycle.
module usb11_res_buf (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        ready,
    output logic [15:0] head,
    output logic        valid,
    output logic        drop
);

    logic [15:0] slot0;
    logic [15:0] slot1;
    logic [1:0]  count;
    logic        pop;
    logic        take;

    assign valid = (count != 2'd0);
    assign head  = slot0;
    assign pop   = valid & ready;
    assign drop  = push & (count == 2'd2) & ~pop;
    assign take  = push & ~drop;

    // Shift-style storage update and occupancy count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({take, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_data;
                    else               slot1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/usb11_mctrl.sv
// USB 1.1 master controller: command decode, byte/packet send, receive with
// timeout and frame abort, automatic ACK handshake, frame-aligned channel control.
//
// state  | meaning
// IDLE   | waiting for a command
// DECODE | latched command is decoded, result or send is set up
// SLOT   | PKT byte waits for the packet slot pulse
// SENT   | byte handed to sender, waiting for it to move on
// RDATA  | receiving device bytes, timeout / frame abort armed
// GAP    | idle gap before the handshake
// SYNC   | SYNC byte sent, waiting for sender to take the next byte
// PID    | ACK PID sent as last byte, waiting for packet end
module usb11_mctrl
    import usb11_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ACK_GAP    = 16,
    parameter int RX_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       cmd_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [15:0]       res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        tx_byte,
    output logic              tx_wr,
    output logic              tx_last,
    input  logic              tx_show_next,
    input  logic              tx_pkt_end,
    input  logic              tx_bus_ena,
    input  logic              frame_eof,
    input  logic              pkt_slot,
    input  logic [7:0]        rx_byte,
    input  logic              rx_rdy,
    input  logic              rx_end,
    input  logic [NUM_CH-1:0] line_dp,
    input  logic [NUM_CH-1:0] line_dm,
    output logic [2:0]        ch_sel,
    output logic [NUM_CH-1:0] ch_rst,
    output logic [NUM_CH-1:0] ch_ena
);

    localparam logic [3:0]  NUM_CH_L = 4'(NUM_CH);
    localparam logic [15:0] GAP_LAST = 16'(ACK_GAP - 1);
    localparam logic [15:0] TMO_LAST = 16'(RX_TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [15:0]       cmd_q;
    logic              aa_q;
    logic              tx_wr_q;
    logic              out_en;
    logic              ovf;
    logic              got_byte;
    logic [15:0]       cnt;
    logic [NUM_CH-1:0] rst_stg;
    logic [NUM_CH-1:0] ena_stg;
    logic              push;
    logic [15:0]       push_data;
    logic              buf_drop;
    logic [15:0]       lines_bits;
    logic [1:0]        op;
    logic [2:0]        ch_in;
    logic              ch_ok;
    logic              rx_take;
    logic              lines_push;
    logic [5:0]        unused_bits;

    assign op          = cmd_q[15:14];
    assign ch_in       = cmd_q[10:8];
    assign ch_ok       = ({1'b0, ch_in} < NUM_CH_L);
    assign rx_take     = rx_rdy & ~tx_bus_ena;
    assign lines_push  = (state == ST_DECODE) && ch_ok && (op == OP_LINES);
    assign cmd_ready   = out_en && (state == ST_IDLE);
    assign tx_wr       = tx_wr_q | ((state == ST_SLOT) & pkt_slot);
    assign unused_bits = {cmd_q[11], lines_bits[15:11]};

    // Interleave the current line levels, dp in the odd bit of each pair.
    always_comb begin
        lines_bits = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lines_bits[2*i+1] = line_dp[i];
            lines_bits[2*i]   = line_dm[i];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state and result-push decode.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_data  = '0;
        case (state)
            ST_IDLE: if (cmd_valid && cmd_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                if (!ch_ok) begin
                    push       = 1'b1;
                    push_data  = {TAG_BADCH, 4'h0, cmd_q[7:0]};
                    state_next = ST_IDLE;
                end else begin
                    case (op)
                        OP_BYTE: state_next = ST_SENT;
                        OP_PKT:  state_next = ST_SLOT;
                        OP_LINES: begin
                            push       = 1'b1;
                            push_data  = {TAG_LINES, ovf, lines_bits[10:0]};
                            state_next = ST_IDLE;
                        end
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
            ST_SLOT: if (pkt_slot) state_next = ST_SENT;
            ST_SENT: if (tx_show_next || tx_pkt_end) state_next = aa_q ? ST_RDATA : ST_IDLE;
            ST_RDATA: begin
                if (rx_take) begin
                    push      = 1'b1;
                    push_data = {TAG_DATA, 4'h0, rx_byte};
                end
                if (rx_end) begin
                    state_next = ST_GAP;
                end else if (frame_eof && !rx_take) begin
                    push       = 1'b1;
                    push_data  = {TAG_FRAME, 9'b0, ch_sel};
                    state_next = ST_IDLE;
                end else if (!got_byte && !rx_take && cnt == TMO_LAST) begin
                    push       = 1'b1;
                    push_data  = {TAG_TMO, 9'b0, ch_sel};
                    state_next = ST_IDLE;
                end
            end
            ST_GAP:  if (cnt == GAP_LAST) state_next = ST_SYNC;
            ST_SYNC: if (tx_show_next) state_next = ST_PID;
            ST_PID:  if (tx_pkt_end) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Command latch, sender interface, channel control, overflow and timers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_en   <= 1'b0;
            cmd_q    <= '0;
            aa_q     <= 1'b0;
            ch_sel   <= '0;
            tx_byte  <= '0;
            tx_last  <= 1'b0;
            tx_wr_q  <= 1'b0;
            rst_stg  <= '0;
            ena_stg  <= '0;
            ch_rst   <= '0;
            ch_ena   <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
            got_byte <= 1'b0;
        end else begin
            out_en  <= 1'b1;
            tx_wr_q <= 1'b0;
            if (state == ST_IDLE && cmd_valid && cmd_ready) cmd_q <= cmd_data;
            if (state == ST_DECODE && ch_ok) begin
                ch_sel  <= ch_in;
                aa_q    <= cmd_q[12];
                tx_last <= cmd_q[13];
                tx_byte <= cmd_q[7:0];
                if (op == OP_BYTE) tx_wr_q <= 1'b1;
                if (op == OP_CTRL) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_in == 3'(i)) begin
                            rst_stg[i] <= cmd_q[0];
                            ena_stg[i] <= cmd_q[1];
                        end
                    end
                end
            end
            if (state == ST_GAP && state_next == ST_SYNC) begin
                tx_byte <= SYNC_BYTE;
                tx_last <= 1'b0;
                tx_wr_q <= 1'b1;
            end
            if (state == ST_SYNC && state_next == ST_PID) begin
                tx_byte <= ACK_PID;
                tx_last <= 1'b1;
                tx_wr_q <= 1'b1;
            end
            if (frame_eof) begin
                ch_rst <= rst_stg;
                ch_ena <= ena_stg;
            end
            if (buf_drop)        ovf <= 1'b1;
            else if (lines_push) ovf <= 1'b0;
            if (state_next != state)
                cnt <= '0;
            else if ((state == ST_RDATA && !got_byte) || state == ST_GAP)
                cnt <= cnt + 16'd1;
            if (state_next == ST_RDATA && state != ST_RDATA)
                got_byte <= 1'b0;
            else if (state == ST_RDATA && rx_take)
                got_byte <= 1'b1;
        end
    end

    usb11_res_buf u_res_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .ready     (res_ready),
        .head      (res_data),
        .valid     (res_valid),
        .drop      (buf_drop)
    );

endmodule

// File: tb/tb_usb11_mctrl.sv
// Directed bench for usb11_mctrl with NUM_CH=4, ACK_GAP=16, RX_TIMEOUT=255.
module tb_usb11_mctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  tx_byte;
    logic        tx_wr;
    logic        tx_last;
    logic        tx_show_next;
    logic        tx_pkt_end;
    logic        tx_bus_ena;
    logic        frame_eof;
    logic        pkt_slot;
    logic [7:0]  rx_byte;
    logic        rx_rdy;
    logic        rx_end;
    logic [3:0]  line_dp;
    logic [3:0]  line_dm;
    logic [2:0]  ch_sel;
    logic [3:0]  ch_rst;
    logic [3:0]  ch_ena;

    int tot = 0;
    int bad = 0;

    always #5 clk = ~clk;

    usb11_mctrl #(.NUM_CH(4), .ACK_GAP(16), .RX_TIMEOUT(255)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .tx_byte(tx_byte), .tx_wr(tx_wr), .tx_last(tx_last),
        .tx_show_next(tx_show_next), .tx_pkt_end(tx_pkt_end), .tx_bus_ena(tx_bus_ena),
        .frame_eof(frame_eof), .pkt_slot(pkt_slot),
        .rx_byte(rx_byte), .rx_rdy(rx_rdy), .rx_end(rx_end),
        .line_dp(line_dp), .line_dm(line_dm),
        .ch_sel(ch_sel), .ch_rst(ch_rst), .ch_ena(ch_ena)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] w);
        int n = 0;
        cmd_data  = w;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
        tot++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_cmd %h: cmd_ready=%b required 1", w, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic get_res(output logic [15:0] d);
        int n = 0;
        while (res_valid !== 1'b1 && n < 400) begin tick(); n++; end
        tot++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL get_res: res_valid=%b required 1", res_valid);
            d = 'x;
        end else begin
            d = res_data;
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
    endtask

    task automatic pulse_show();
        tx_show_next = 1'b1; tick(); tx_show_next = 1'b0;
    endtask

    task automatic pulse_end();
        tx_pkt_end = 1'b1; tick(); tx_pkt_end = 1'b0;
    endtask

    task automatic pulse_eof();
        frame_eof = 1'b1; tick(); frame_eof = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_data = '0; cmd_valid = 1'b0; res_ready = 1'b0;
        tx_show_next = 1'b0; tx_pkt_end = 1'b0; tx_bus_ena = 1'b0; frame_eof = 1'b0;
        pkt_slot = 1'b0; rx_byte = '0; rx_rdy = 1'b0; rx_end = 1'b0;
        line_dp = '0; line_dm = '0;
        tick(); tick();
        tot++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready_low: got %b want 0", cmd_ready); end
        tot++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        tot++; if (tx_wr !== 1'b0 || tx_last !== 1'b0) begin bad++; $display("FAIL rst_tx: got wr=%b last=%b want 0 0", tx_wr, tx_last); end
        tot++; if (ch_rst !== 4'h0 || ch_ena !== 4'h0 || ch_sel !== 3'd0) begin
            bad++; $display("FAIL rst_ch: got rst=%b ena=%b sel=%0d want 0", ch_rst, ch_ena, ch_sel); end
        reset_n = 1'b1;
        tick();
        tot++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_ctrl();
        send_cmd(16'h0101);
        tick();
        tot++; if (ch_sel !== 3'd1) begin bad++; $display("FAIL ctrl_ch_sel: got %0d want 1", ch_sel); end
        repeat (3) tick();
        tot++; if (ch_rst !== 4'b0000) begin bad++; $display("FAIL ctrl_before_eof: got %b want 0000", ch_rst); end
        pulse_eof();
        tot++; if (ch_rst !== 4'b0010) begin bad++; $display("FAIL ctrl_after_eof: got %b want 0010", ch_rst); end
        send_cmd(16'h0202);
        tick();
        tot++; if (ch_ena !== 4'b0000) begin bad++; $display("FAIL ctrl_ena_before: got %b want 0000", ch_ena); end
        pulse_eof();
        tot++; if (ch_ena !== 4'b0100 || ch_rst !== 4'b0010) begin
            bad++; $display("FAIL ctrl_ena_after: got ena=%b rst=%b want 0100 0010", ch_ena, ch_rst); end
        tot++; if (res_valid !== 1'b0) begin bad++; $display("FAIL ctrl_no_result: got %b want 0", res_valid); end
        send_cmd(16'h0100);
        send_cmd(16'h0200);
        tick();
        pulse_eof();
        tot++; if (ch_ena !== 4'b0000 || ch_rst !== 4'b0000) begin
            bad++; $display("FAIL ctrl_clear: got ena=%b rst=%b want 0", ch_ena, ch_rst); end
    endtask

    task automatic test_pkt_ack();
        logic [7:0]  rxb [3];
        logic [15:0] d;
        int n;
        rxb[0] = 8'h11; rxb[1] = 8'hA5; rxb[2] = 8'h3C;
        send_cmd(16'h8080);
        tick();
        tot++; if (tx_wr !== 1'b0 || tx_byte !== 8'h80) begin
            bad++; $display("FAIL pkt_wait: got wr=%b byte=%h want 0 80", tx_wr, tx_byte); end
        tick(); tick();
        pkt_slot = 1'b1; #1;
        tot++; if (tx_wr !== 1'b1) begin bad++; $display("FAIL pkt_slot_wr: got %b want 1", tx_wr); end
        tick(); pkt_slot = 1'b0; #1;
        tot++; if (tx_wr !== 1'b0) begin bad++; $display("FAIL pkt_wr_one: got %b want 0", tx_wr); end
        pulse_end();
        send_cmd(16'h7069);
        tot++; if (tx_wr !== 1'b0) begin bad++; $display("FAIL byte_decode_wr: got %b want 0", tx_wr); end
        tick();
        tot++; if (tx_wr !== 1'b1 || tx_byte !== 8'h69 || tx_last !== 1'b1) begin
            bad++; $display("FAIL byte_wr: got wr=%b byte=%h last=%b want 1 69 1", tx_wr, tx_byte, tx_last); end
        tick();
        tot++; if (tx_wr !== 1'b0) begin bad++; $display("FAIL byte_wr_one: got %b want 0", tx_wr); end
        pulse_show();
        tx_bus_ena = 1'b1; rx_byte = 8'hEE; rx_rdy = 1'b1; tick(); rx_rdy = 1'b0; tx_bus_ena = 1'b0;
        tick();
        tot++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rx_bus_ena_gate: got %b want 0", res_valid); end
        for (int i = 0; i < 3; i++) begin
            rx_byte = rxb[i]; rx_rdy = 1'b1; tick(); rx_rdy = 1'b0;
            get_res(d);
            tot++; if (d !== {8'h00, rxb[i]}) begin bad++; $display("FAIL rx_data%0d: got %h want %h", i, d, {8'h00, rxb[i]}); end
        end
        rx_end = 1'b1; tick(); rx_end = 1'b0;
        n = 0;
        while (tx_wr !== 1'b1 && n < 40) begin tick(); n++; end
        tot++; if (n != 16) begin bad++; $display("FAIL ack_gap: got %0d cycles want 16", n); end
        tot++; if (tx_byte !== 8'h80 || tx_last !== 1'b0) begin
            bad++; $display("FAIL ack_sync: got byte=%h last=%b want 80 0", tx_byte, tx_last); end
        pulse_show();
        tot++; if (tx_wr !== 1'b1 || tx_byte !== 8'hD2 || tx_last !== 1'b1) begin
            bad++; $display("FAIL ack_pid: got wr=%b byte=%h last=%b want 1 d2 1", tx_wr, tx_byte, tx_last); end
        pulse_end();
        tot++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++; $display("FAIL ack_done: got ready=%b valid=%b want 1 0", cmd_ready, res_valid); end
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        int wr = 0;
        int n = 0;
        send_cmd(16'h5355);
        tick();
        pulse_show();
        repeat (200) begin tick(); if (tx_wr === 1'b1) wr++; end
        tot++; if (res_valid !== 1'b0) begin bad++; $display("FAIL tmo_early: got valid=%b want 0", res_valid); end
        while (res_valid !== 1'b1 && n < 100) begin tick(); n++; end
        get_res(d);
        tot++; if (d !== 16'hE003) begin bad++; $display("FAIL tmo_result: got %h want e003", d); end
        tot++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL tmo_idle: got ready=%b want 1", cmd_ready); end
        repeat (30) begin tick(); if (tx_wr === 1'b1) wr++; end
        tot++; if (wr != 0) begin bad++; $display("FAIL tmo_no_ack: got %0d writes want 0", wr); end
    endtask

    task automatic test_frame();
        logic [15:0] d;
        int n = 0;
        send_cmd(16'h5211);
        tick();
        pulse_show();
        tick();
        pulse_eof();
        get_res(d);
        tot++; if (d !== 16'hD002) begin bad++; $display("FAIL frame_abort: got %h want d002", d); end
        tot++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL frame_idle: got %b want 1", cmd_ready); end
        send_cmd(16'h5211);
        tick();
        pulse_show();
        tick();
        rx_end = 1'b1; frame_eof = 1'b1; tick(); rx_end = 1'b0; frame_eof = 1'b0;
        tick();
        tot++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rxend_wins_res: got valid=%b want 0", res_valid); end
        while (tx_wr !== 1'b1 && n < 40) begin tick(); n++; end
        tot++; if (tx_wr !== 1'b1 || tx_byte !== 8'h80) begin
            bad++; $display("FAIL rxend_wins_ack: got wr=%b byte=%h want 1 80", tx_wr, tx_byte); end
        pulse_show();
        pulse_end();
    endtask

    task automatic test_bad_ch();
        logic [15:0] d;
        int wr = 0;
        send_cmd(16'h45AB);
        repeat (5) begin tick(); if (tx_wr === 1'b1) wr++; end
        tot++; if (wr != 0) begin bad++; $display("FAIL badch_no_wr: got %0d writes want 0", wr); end
        get_res(d);
        tot++; if (d !== 16'hC0AB) begin bad++; $display("FAIL badch_result: got %h want c0ab", d); end
        send_cmd(16'h8400);
        pkt_slot = 1'b1; #1;
        tot++; if (tx_wr !== 1'b0) begin bad++; $display("FAIL badch_pkt_wr: got %b want 0", tx_wr); end
        tick(); pkt_slot = 1'b0;
        get_res(d);
        tot++; if (d !== 16'hC000) begin bad++; $display("FAIL badch_pkt_result: got %h want c000", d); end
        line_dp = 4'b0001; line_dm = 4'b0010;
        send_cmd(16'hC000);
        get_res(d);
        tot++; if (d !== 16'hF006) begin bad++; $display("FAIL lines_a: got %h want f006", d); end
        line_dp = 4'b1010; line_dm = 4'b0101;
        send_cmd(16'hC000);
        get_res(d);
        tot++; if (d !== 16'hF099) begin bad++; $display("FAIL lines_b: got %h want f099", d); end
        line_dp = 4'b0001; line_dm = 4'b0010;
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        send_cmd(16'h4501);
        send_cmd(16'h4502);
        send_cmd(16'h4503);
        tick(); tick();
        get_res(d);
        tot++; if (d !== 16'hC001) begin bad++; $display("FAIL ovf_first: got %h want c001", d); end
        get_res(d);
        tot++; if (d !== 16'hC002) begin bad++; $display("FAIL ovf_second: got %h want c002", d); end
        tick();
        tot++; if (res_valid !== 1'b0) begin bad++; $display("FAIL ovf_third_dropped: got valid=%b want 0", res_valid); end
        send_cmd(16'hC000);
        get_res(d);
        tot++; if (d !== 16'hF806) begin bad++; $display("FAIL ovf_flag_set: got %h want f806", d); end
        send_cmd(16'hC000);
        get_res(d);
        tot++; if (d !== 16'hF006) begin bad++; $display("FAIL ovf_flag_clear: got %h want f006", d); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [15:0] d0;
        send_cmd(16'h4511);
        send_cmd(16'h4512);
        tick(); tick();
        send_cmd(16'h4513);
        d0 = res_data;
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        tot++; if (d0 !== 16'hC011) begin bad++; $display("FAIL full_pp_head: got %h want c011", d0); end
        get_res(d);
        tot++; if (d !== 16'hC012) begin bad++; $display("FAIL full_pp_second: got %h want c012", d); end
        get_res(d);
        tot++; if (d !== 16'hC013) begin bad++; $display("FAIL full_pp_third: got %h want c013", d); end
        send_cmd(16'hC000);
        get_res(d);
        tot++; if (d !== 16'hF006) begin bad++; $display("FAIL full_pp_no_ovf: got %h want f006", d); end
    endtask

    task automatic test_reset_mid();
        int wr = 0;
        send_cmd(16'h0303);
        tick();
        pulse_eof();
        tot++; if (ch_rst !== 4'b1000 || ch_ena !== 4'b1000) begin
            bad++; $display("FAIL mid_pre_ch: got rst=%b ena=%b want 1000 1000", ch_rst, ch_ena); end
        send_cmd(16'h4566);
        tick(); tick();
        send_cmd(16'h7177);
        tick();
        tot++; if (tx_wr !== 1'b1 || res_valid !== 1'b1) begin
            bad++; $display("FAIL mid_pre_state: got wr=%b valid=%b want 1 1", tx_wr, res_valid); end
        reset_n = 1'b0;
        tick();
        tot++; if (tx_wr !== 1'b0 || tx_last !== 1'b0 || tx_byte !== 8'h00) begin
            bad++; $display("FAIL mid_tx_zero: got wr=%b last=%b byte=%h want 0 0 00", tx_wr, tx_last, tx_byte); end
        tot++; if (res_valid !== 1'b0 || res_data !== 16'h0000) begin
            bad++; $display("FAIL mid_res_zero: got valid=%b data=%h want 0 0000", res_valid, res_data); end
        tot++; if (ch_rst !== 4'h0 || ch_ena !== 4'h0 || ch_sel !== 3'd0 || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL mid_ch_zero: got rst=%b ena=%b sel=%0d ready=%b want 0", ch_rst, ch_ena, ch_sel, cmd_ready); end
        reset_n = 1'b1;
        tick();
        tot++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready: got %b want 1", cmd_ready); end
        tx_show_next = 1'b1; tx_pkt_end = 1'b1; pkt_slot = 1'b1; rx_rdy = 1'b1; rx_end = 1'b1;
        tick(); if (tx_wr === 1'b1) wr++;
        tx_show_next = 1'b0; tx_pkt_end = 1'b0; pkt_slot = 1'b0; rx_rdy = 1'b0; rx_end = 1'b0;
        pulse_eof();
        repeat (30) begin tick(); if (tx_wr === 1'b1) wr++; end
        tot++; if (wr != 0) begin bad++; $display("FAIL mid_no_wr: got %0d writes want 0", wr); end
        tot++; if (ch_rst !== 4'h0 || ch_ena !== 4'h0) begin
            bad++; $display("FAIL mid_staging_cleared: got rst=%b ena=%b want 0", ch_rst, ch_ena); end
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_pkt_ack();
        test_timeout();
        test_frame();
        test_bad_ch();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
